// File: rtl/spi_deserializer.sv
// spi_deserializer
//
// Receives MSB-first SPI words from an upstream serializer whose sclk is
// derived from clk, and writes each completed word into a downstream FIFO.
// A done pulse that arrives before a full word has been shifted in is
// reported as a frame error. A completed word that meets a full FIFO is
// dropped and reported as an overflow.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   sclk         SPI serial clock (idle low)
//   mosi         serial data, sampled on sclk rising edge
//   done         one-cycle end-of-word pulse from the serializer
//   full         downstream FIFO full flag
//   write_en     one-cycle FIFO write strobe
//   write_data   received word, valid while write_en=1, otherwise held
//   overflow     one-cycle pulse: completed word dropped because full=1
//   frame_error  one-cycle pulse: done before DATA_WIDTH bits
//   rx_words     count of words written to the FIFO (wraps silently)
module spi_deserializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  done,
    input  logic                  full,
    output logic                  write_en,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  overflow,
    output logic                  frame_error,
    output logic [15:0]           rx_words
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RECEIVE = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic                  sclk_q, sclk_prev, mosi_q, done_q;
    logic                  write_en_d, overflow_d, frame_error_d;
    logic [DATA_WIDTH-1:0] write_data_d;
    logic [15:0]           rx_words_d;

    logic                  rise;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [CNT_W-1:0]      cnt_inc;

    assign rise       = sclk_q & ~sclk_prev;
    assign shift_next = {shift_reg_q[DATA_WIDTH-2:0], mosi_q};
    assign cnt_inc    = bit_cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_reg_d   = shift_reg_q;
        write_en_d    = 1'b0;
        overflow_d    = 1'b0;
        frame_error_d = 1'b0;
        write_data_d  = write_data;
        // write_en is only ever high during WRITE, so this lands at the end of that cycle.
        rx_words_d    = write_en ? rx_words + 16'd1 : rx_words;

        case (state_q)
            IDLE: begin
                // done_q is deliberately ignored here: it trails every completed word.
                if (rise) begin
                    shift_reg_d = shift_next;
                    bit_cnt_d   = CNT_W'(1);
                    state_d     = RECEIVE;
                end
            end
            RECEIVE: begin
                if (rise) begin
                    shift_reg_d = shift_next;
                    bit_cnt_d   = cnt_inc;
                end
                if (rise && cnt_inc == LAST_CNT) begin
                    // Strobes are registered, so the write/overflow decision is taken on the
                    // edge entering WRITE and is visible for exactly the WRITE cycle.
                    state_d   = WRITE;
                    bit_cnt_d = '0;
                    if (full) begin
                        overflow_d = 1'b1;
                    end else begin
                        write_en_d   = 1'b1;
                        write_data_d = shift_next;
                    end
                end else if (done_q) begin
                    frame_error_d = 1'b1;
                    bit_cnt_d     = '0;
                    state_d       = IDLE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_reg_q <= '0;
            sclk_q      <= 1'b0;
            sclk_prev   <= 1'b0;
            mosi_q      <= 1'b0;
            done_q      <= 1'b0;
            write_en    <= 1'b0;
            overflow    <= 1'b0;
            frame_error <= 1'b0;
            write_data  <= '0;
            rx_words    <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_reg_q <= shift_reg_d;
            sclk_q      <= sclk;
            sclk_prev   <= sclk_q;
            mosi_q      <= mosi;
            done_q      <= done;
            write_en    <= write_en_d;
            overflow    <= overflow_d;
            frame_error <= frame_error_d;
            write_data  <= write_data_d;
            rx_words    <= rx_words_d;
        end
    end

endmodule

// File: tb/tb_spi_deserializer.sv
// tb_spi_deserializer
//
// Directed stimulus for spi_deserializer (DATA_WIDTH=8). Each sent word or
// done pulse queues the outcome it must produce (write, overflow or frame
// error, the data and the cycle it must appear in). A single negedge
// process matches DUT strobes against that queue and tracks the expected
// write count and held write_data. Literal checks after each scenario pin
// the model to hand-computed values.
module tb_spi_deserializer;

    localparam int unsigned W = 8;

    localparam int K_WRITE = 0;
    localparam int K_OVF   = 1;
    localparam int K_FERR  = 2;

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic         sclk = 1'b0;
    logic         mosi = 1'b0;
    logic         done = 1'b0;
    logic         full = 1'b0;
    logic         write_en;
    logic [W-1:0] write_data;
    logic         overflow;
    logic         frame_error;
    logic [15:0]  rx_words;

    spi_deserializer #(.DATA_WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .mosi        (mosi),
        .done        (done),
        .full        (full),
        .write_en    (write_en),
        .write_data  (write_data),
        .overflow    (overflow),
        .frame_error (frame_error),
        .rx_words    (rx_words)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           kind;
        logic [W-1:0] data;
        int           cyc;
    } ev_t;

    ev_t          exp_q[$];
    int           n_cmp      = 0;
    int           n_bad      = 0;
    int           cyc        = 0;
    logic         rst_seen   = 1'b1;
    logic [15:0]  exp_words  = '0;
    logic [W-1:0] exp_data   = '0;
    bit           prev_pulse = 1'b0;
    bit           preload    = 1'b0;

    // Compare-process scratch.
    bit           pulse;
    int           kind_act;
    ev_t          e_cur;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name, input int act, input int req);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    endtask

    always @(negedge clk) begin
        if (rst_seen) begin
            check("reset write_en", 32'(write_en), 32'd0);
            check("reset overflow", 32'(overflow), 32'd0);
            check("reset frame_error", 32'(frame_error), 32'd0);
            check("reset write_data", 32'(write_data), 32'd0);
            check("reset rx_words", 32'(rx_words), 32'd0);
            exp_words  = '0;
            exp_data   = '0;
            prev_pulse = 1'b0;
            exp_q.delete();
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                flag("missing strobe kind", -1, exp_q[0].kind);
                void'(exp_q.pop_front());
            end
            pulse = write_en | overflow | frame_error;
            check("strobes exclusive", 32'($countones({write_en, overflow, frame_error}) > 1),
                  32'd0);
            check("no back-to-back strobe", 32'(prev_pulse & pulse), 32'd0);
            if (pulse) begin
                kind_act = write_en ? K_WRITE : (overflow ? K_OVF : K_FERR);
                if (exp_q.size() == 0) begin
                    flag("unexpected strobe kind", kind_act, -1);
                end else begin
                    e_cur = exp_q.pop_front();
                    check("strobe kind", 32'(kind_act), 32'(e_cur.kind));
                    check("strobe cycle", 32'(cyc), 32'(e_cur.cyc));
                    if (e_cur.kind == K_WRITE) begin
                        exp_data = e_cur.data;
                    end
                end
            end
            if (!preload) begin
                check("rx_words", 32'(rx_words), 32'(exp_words));
            end
            check("write_data", 32'(write_data), 32'(exp_data));
            if (pulse && exp_q.size() >= 0 && e_cur.kind == K_WRITE && e_cur.cyc == cyc) begin
                exp_words = exp_words + 16'd1;
            end
            prev_pulse = pulse;
        end
    end

    task automatic push_ev(input int kind, input logic [W-1:0] data, input int at);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Drives the top nbits of word MSB first, 4 clk per bit (sclk high for 2).
    // done_last raises done together with the last sclk rise.
    task automatic send_bits(input logic [W-1:0] word, input int nbits, input bit done_last);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            mosi = word[W-1-i];
            @(negedge clk);
            // The shift lands 2 edges after sclk goes high; strobes show up right after it.
            if (i == W - 1) begin
                push_ev(full ? K_OVF : K_WRITE, word, cyc + 2);
            end else if (done_last && i == nbits - 1) begin
                push_ev(K_FERR, '0, cyc + 2);
            end
            sclk = 1'b1;
            if (done_last && i == nbits - 1) begin
                done = 1'b1;
            end
            @(negedge clk);
            done = 1'b0;
            @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic pulse_done(input bit expect_ferr);
        @(negedge clk);
        if (expect_ferr) begin
            push_ev(K_FERR, '0, cyc + 2);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle(3);
        check("pin reset write_data", 32'(write_data), 32'h00);
        check("pin reset rx_words", 32'(rx_words), 32'h0000);
        rst = 1'b0;

        // Plain word into an empty FIFO.
        full = 1'b0;
        send_bits(8'hA5, 8, 1'b0);
        pulse_done(1'b0);
        idle(4);
        check("pin A5 data", 32'(write_data), 32'hA5);
        check("pin A5 count", 32'(rx_words), 32'd1);

        // Word into a full FIFO is dropped.
        full = 1'b1;
        send_bits(8'h3C, 8, 1'b0);
        pulse_done(1'b0);
        idle(4);
        full = 1'b0;
        check("pin 3C count held", 32'(rx_words), 32'd1);
        check("pin 3C data held", 32'(write_data), 32'hA5);

        // Short frame, then a good word.
        send_bits(8'h5A, 5, 1'b0);
        pulse_done(1'b1);
        idle(4);
        send_bits(8'hC3, 8, 1'b0);
        idle(4);
        check("pin C3 data", 32'(write_data), 32'hC3);
        check("pin C3 count", 32'(rx_words), 32'd2);

        // done coinciding with a rise: short frame, then exactly on the last bit.
        send_bits(8'h96, 3, 1'b1);
        idle(4);
        check("pin short+rise count", 32'(rx_words), 32'd2);
        send_bits(8'h69, 8, 1'b1);
        idle(4);
        check("pin 69 data", 32'(write_data), 32'h69);
        check("pin 69 count", 32'(rx_words), 32'd3);

        // Reset mid-frame discards partial bits and the count.
        send_bits(8'h0F, 4, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        send_bits(8'hFF, 8, 1'b0);
        idle(4);
        check("pin FF data", 32'(write_data), 32'hFF);
        check("pin FF count", 32'(rx_words), 32'd1);

        // Back-to-back words.
        send_bits(8'h01, 8, 1'b0);
        send_bits(8'h80, 8, 1'b0);
        idle(4);
        check("pin 80 data", 32'(write_data), 32'h80);
        check("pin b2b count", 32'(rx_words), 32'd3);

        // Counter wrap: preload 0xFFFF successful words, then one more.
        @(negedge clk);
        preload = 1'b1;
        force dut.rx_words = 16'hFFFF;
        @(negedge clk);
        release dut.rx_words;
        exp_words = 16'hFFFF;
        preload   = 1'b0;
        idle(2);
        check("pin preload count", 32'(rx_words), 32'hFFFF);
        send_bits(8'h5A, 8, 1'b0);
        idle(4);
        check("pin wrap count", 32'(rx_words), 32'h0000);
        check("pin wrap data", 32'(write_data), 32'h5A);

        idle(4);
        check("all expected strobes seen", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
